// File: rtl/risc16_pkg.sv
// Shared definitions for the multi-cycle RiSC-16 core: opcodes, FSM states,
// instruction field positions and the imm7 sign-extension helper.
package risc16_pkg;

   localparam int unsigned INSTR_LEN    = 16;
   // Widest datapath the sign-extension helper supports.
   localparam int unsigned MAX_WORD_LEN = 64;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_ADDI = 3'b001;
   localparam logic [2:0] OP_NAND = 3'b010;
   localparam logic [2:0] OP_LUI  = 3'b011;
   localparam logic [2:0] OP_SW   = 3'b100;
   localparam logic [2:0] OP_LW   = 3'b101;
   localparam logic [2:0] OP_BEQ  = 3'b110;
   localparam logic [2:0] OP_JALR = 3'b111;

   localparam int unsigned OP_MSB    = 15;
   localparam int unsigned OP_LSB    = 13;
   localparam int unsigned RA_MSB    = 12;
   localparam int unsigned RA_LSB    = 10;
   localparam int unsigned RB_MSB    = 9;
   localparam int unsigned RB_LSB    = 7;
   localparam int unsigned RC_MSB    = 2;
   localparam int unsigned RC_LSB    = 0;
   localparam int unsigned IMM7_MSB  = 6;
   localparam int unsigned IMM10_MSB = 9;

   typedef enum logic [1:0] {StFetch, StExec, StMem, StHalt} state_t;

   // Sign-extend imm7 to the widest supported word; callers truncate to their width.
   function automatic logic [MAX_WORD_LEN-1:0] sext7(input logic [6:0] imm);
      return {{(MAX_WORD_LEN - 7){imm[6]}}, imm};
   endfunction

endpackage

// File: rtl/risc16_regfile.sv
// Two-read / one-write register file with r0 hardwired to zero.
module risc16_regfile #(
   parameter int unsigned p_WORD_LEN      = 16,
   parameter int unsigned p_REG_ADDR_LEN  = 3,
   parameter int unsigned p_REG_FILE_SIZE = 8
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [p_REG_ADDR_LEN-1:0] i_raddr_a,
   output logic [p_WORD_LEN-1:0]     o_rdata_a,
   input  logic [p_REG_ADDR_LEN-1:0] i_raddr_b,
   output logic [p_WORD_LEN-1:0]     o_rdata_b,
   input  logic                      i_we,
   input  logic [p_REG_ADDR_LEN-1:0] i_waddr,
   input  logic [p_WORD_LEN-1:0]     i_wdata
);

   logic [p_WORD_LEN-1:0] regs_q [p_REG_FILE_SIZE];

   // Register storage; writes to r0 or beyond the file are dropped.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int unsigned i = 0; i < p_REG_FILE_SIZE; i++) begin
            regs_q[i] <= '0;
         end
      end else if (i_we && (i_waddr != '0) && (32'(i_waddr) < p_REG_FILE_SIZE)) begin
         regs_q[i_waddr] <= i_wdata;
      end
   end

   // Asynchronous reads; r0 and unimplemented indices read as zero.
   always_comb begin
      o_rdata_a = '0;
      o_rdata_b = '0;
      if ((i_raddr_a != '0) && (32'(i_raddr_a) < p_REG_FILE_SIZE)) begin
         o_rdata_a = regs_q[i_raddr_a];
      end
      if ((i_raddr_b != '0) && (32'(i_raddr_b) < p_REG_FILE_SIZE)) begin
         o_rdata_b = regs_q[i_raddr_b];
      end
   end

endmodule

// File: rtl/risc16_mc_core.sv
// Multi-cycle RiSC-16 core: FETCH/EXEC/MEM/HALT FSM driving handshaked
// instruction and data memory ports. Word width up to MAX_WORD_LEN.
module risc16_mc_core
   import risc16_pkg::*;
#(
   parameter int unsigned           p_WORD_LEN      = 16,
   parameter int unsigned           p_REG_ADDR_LEN  = 3,
   parameter int unsigned           p_REG_FILE_SIZE = 8,
   parameter logic [p_WORD_LEN-1:0] p_RESET_PC      = '0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   output logic                  o_imem_req,
   output logic [p_WORD_LEN-1:0] o_imem_addr,
   input  logic                  i_imem_ack,
   input  logic [INSTR_LEN-1:0]  i_imem_data,
   output logic                  o_dmem_req,
   output logic                  o_dmem_we,
   output logic [p_WORD_LEN-1:0] o_dmem_addr,
   output logic [p_WORD_LEN-1:0] o_dmem_wdata,
   input  logic                  i_dmem_ack,
   input  logic [p_WORD_LEN-1:0] i_dmem_rdata,
   output logic                  o_retire,
   output logic                  o_halted
);

   state_t                      state_q, state_d;
   logic [p_WORD_LEN-1:0]       pc_q, pc_d;
   logic [INSTR_LEN-1:0]        ir_q, ir_d;
   logic                        retire_q, retire_d;

   logic [2:0]                  op;
   logic                        is_halt;
   logic [p_REG_ADDR_LEN-1:0]   raddr_a, raddr_b, waddr;
   logic [p_WORD_LEN-1:0]       rdata_a, rdata_b;
   logic [p_WORD_LEN-1:0]       imm7_sext, lui_val, pc_inc, mem_addr;
   logic                        rf_we;
   logic [p_WORD_LEN-1:0]       rf_wdata;

   assign op        = ir_q[OP_MSB:OP_LSB];
   assign is_halt   = (ir_q[IMM7_MSB:0] != '0);
   assign imm7_sext = p_WORD_LEN'(sext7(ir_q[IMM7_MSB:0]));
   assign lui_val   = p_WORD_LEN'({ir_q[IMM10_MSB:0], 6'b0});
   assign pc_inc    = pc_q + p_WORD_LEN'(1);
   assign mem_addr  = rdata_b + imm7_sext;

   // Port B always reads rB; port A reads rC for ADD/NAND, otherwise rA.
   assign raddr_a = ((op == OP_ADD) || (op == OP_NAND)) ?
                    p_REG_ADDR_LEN'(ir_q[RC_MSB:RC_LSB]) : p_REG_ADDR_LEN'(ir_q[RA_MSB:RA_LSB]);
   assign raddr_b = p_REG_ADDR_LEN'(ir_q[RB_MSB:RB_LSB]);
   assign waddr   = p_REG_ADDR_LEN'(ir_q[RA_MSB:RA_LSB]);

   risc16_regfile #(
      .p_WORD_LEN      (p_WORD_LEN),
      .p_REG_ADDR_LEN  (p_REG_ADDR_LEN),
      .p_REG_FILE_SIZE (p_REG_FILE_SIZE)
   ) u_regfile (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_raddr_a (raddr_a),
      .o_rdata_a (rdata_a),
      .i_raddr_b (raddr_b),
      .o_rdata_b (rdata_b),
      .i_we      (rf_we),
      .i_waddr   (waddr),
      .i_wdata   (rf_wdata)
   );

   // FSM state register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; each state only advances on its own handshake.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFetch: if (i_imem_ack) state_d = StExec;
         StExec: begin
            if ((op == OP_SW) || (op == OP_LW)) begin
               state_d = StMem;
            end else if ((op == OP_JALR) && is_halt) begin
               state_d = StHalt;
            end else begin
               state_d = StFetch;
            end
         end
         StMem:  if (i_dmem_ack) state_d = StFetch;
         StHalt: state_d = StHalt;
         default: state_d = StFetch;
      endcase
   end

   // Outputs, ALU, register write and PC/IR next values per state.
   always_comb begin
      o_imem_req   = 1'b0;
      o_dmem_req   = 1'b0;
      o_dmem_we    = 1'b0;
      o_dmem_addr  = '0;
      o_dmem_wdata = '0;
      pc_d         = pc_q;
      ir_d         = ir_q;
      retire_d     = 1'b0;
      rf_we        = 1'b0;
      rf_wdata     = '0;
      unique case (state_q)
         StFetch: begin
            // Gated by reset so a request never appears while reset is held.
            o_imem_req = ~i_rst;
            if (i_imem_ack) ir_d = i_imem_data;
         end
         StExec: begin
            retire_d = 1'b1;
            pc_d     = pc_inc;
            unique case (op)
               OP_ADD: begin
                  rf_we    = 1'b1;
                  rf_wdata = rdata_b + rdata_a;
               end
               OP_ADDI: begin
                  rf_we    = 1'b1;
                  rf_wdata = rdata_b + imm7_sext;
               end
               OP_NAND: begin
                  rf_we    = 1'b1;
                  rf_wdata = ~(rdata_b & rdata_a);
               end
               OP_LUI: begin
                  rf_we    = 1'b1;
                  rf_wdata = lui_val;
               end
               OP_SW, OP_LW: begin
                  retire_d = 1'b0;
                  pc_d     = pc_q;
               end
               OP_BEQ: begin
                  if (rdata_a == rdata_b) pc_d = pc_inc + imm7_sext;
               end
               OP_JALR: begin
                  if (is_halt) begin
                     pc_d = pc_q;
                  end else begin
                     // rB was read before the edge, so rA == rB still jumps to the old value.
                     rf_we    = 1'b1;
                     rf_wdata = pc_inc;
                     pc_d     = rdata_b;
                  end
               end
               default: ;
            endcase
         end
         StMem: begin
            o_dmem_req   = 1'b1;
            o_dmem_we    = (op == OP_SW);
            o_dmem_addr  = mem_addr;
            o_dmem_wdata = rdata_a;
            if (i_dmem_ack) begin
               retire_d = 1'b1;
               pc_d     = pc_inc;
               if (op == OP_LW) begin
                  rf_we    = 1'b1;
                  rf_wdata = i_dmem_rdata;
               end
            end
         end
         StHalt: ;
         default: ;
      endcase
   end

   // PC, instruction register and retire strobe.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pc_q     <= p_RESET_PC;
         ir_q     <= '0;
         retire_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         retire_q <= retire_d;
      end
   end

   assign o_imem_addr = pc_q;
   assign o_retire    = retire_q;
   assign o_halted    = (state_q == StHalt);

endmodule

// File: tb/tb_risc16_mc_core.sv
// Directed bench for risc16_mc_core at W=16; drives and samples on the falling edge.
module tb_risc16_mc_core;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        o_imem_req;
   logic [15:0] o_imem_addr;
   logic        i_imem_ack = 1'b0;
   logic [15:0] i_imem_data = '0;
   logic        o_dmem_req;
   logic        o_dmem_we;
   logic [15:0] o_dmem_addr;
   logic [15:0] o_dmem_wdata;
   logic        i_dmem_ack = 1'b0;
   logic [15:0] i_dmem_rdata = '0;
   logic        o_retire;
   logic        o_halted;

   int checks = 0;
   int errors = 0;

   risc16_mc_core #(
      .p_WORD_LEN      (16),
      .p_REG_ADDR_LEN  (3),
      .p_REG_FILE_SIZE (8),
      .p_RESET_PC      (16'h0000)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .o_imem_req   (o_imem_req),
      .o_imem_addr  (o_imem_addr),
      .i_imem_ack   (i_imem_ack),
      .i_imem_data  (i_imem_data),
      .o_dmem_req   (o_dmem_req),
      .o_dmem_we    (o_dmem_we),
      .o_dmem_addr  (o_dmem_addr),
      .o_dmem_wdata (o_dmem_wdata),
      .i_dmem_ack   (i_dmem_ack),
      .i_dmem_rdata (i_dmem_rdata),
      .o_retire     (o_retire),
      .o_halted     (o_halted)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge in FETCH: zero-wait instruction delivery.
   task automatic fetch(input logic [15:0] addr, input logic [15:0] instr);
      chk("fetch_req", 32'(o_imem_req), 32'd1);
      chk("fetch_addr", 32'(o_imem_addr), 32'(addr));
      i_imem_ack  = 1'b1;
      i_imem_data = instr;
      @(negedge i_clk);
      i_imem_ack  = 1'b0;
      i_imem_data = '0;
   endtask

   // Called at a falling edge in EXEC for a non-memory instruction.
   task automatic exec_alu(input logic [15:0] next_pc);
      chk("exec_imem_req", 32'(o_imem_req), 32'd0);
      chk("exec_retire_lo", 32'(o_retire), 32'd0);
      @(negedge i_clk);
      chk("exec_retire", 32'(o_retire), 32'd1);
      chk("exec_next_pc", 32'(o_imem_addr), 32'(next_pc));
   endtask

   // Called at a falling edge in EXEC for LW/SW; acks after 'waits' idle MEM cycles.
   task automatic mem_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                             input logic [15:0] rdata, input int waits);
      chk("mem_exec_dreq", 32'(o_dmem_req), 32'd0);
      @(negedge i_clk);
      for (int i = 0; i <= waits; i++) begin
         chk("mem_req", 32'(o_dmem_req), 32'd1);
         chk("mem_we", 32'(o_dmem_we), 32'(we));
         chk("mem_addr", 32'(o_dmem_addr), 32'(addr));
         chk("mem_retire_lo", 32'(o_retire), 32'd0);
         if (we) chk("mem_wdata", 32'(o_dmem_wdata), 32'(wdata));
         if (i == waits) begin
            i_dmem_ack   = 1'b1;
            i_dmem_rdata = rdata;
         end
         @(negedge i_clk);
      end
      i_dmem_ack   = 1'b0;
      i_dmem_rdata = '0;
      chk("mem_retire", 32'(o_retire), 32'd1);
      chk("mem_idle_req", 32'(o_dmem_req), 32'd0);
      chk("mem_idle_addr", 32'(o_dmem_addr), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      @(negedge i_clk);
      chk("rst_dreq", 32'(o_dmem_req), 32'd0);
      chk("rst_retire", 32'(o_retire), 32'd0);
      chk("rst_halted", 32'(o_halted), 32'd0);
      @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);
      chk("rst_imem_req", 32'(o_imem_req), 32'd1);
      chk("rst_we", 32'(o_dmem_we), 32'd0);
      chk("rst_daddr", 32'(o_dmem_addr), 32'd0);
      chk("rst_wdata", 32'(o_dmem_wdata), 32'd0);

      fetch(16'd0, 16'h2405);                              // addi r1,r0,5
      exec_alu(16'd1);
      fetch(16'd1, 16'h0081);                              // add r0,r1,r1
      exec_alu(16'd2);
      fetch(16'd2, 16'h8400);                              // sw r1,r0,0 -> 5
      mem_access(1'b1, 16'h0000, 16'h0005, 16'h0000, 0);
      fetch(16'd3, 16'h8080);                              // sw r0,r1,0 -> r0 stays 0
      mem_access(1'b1, 16'h0005, 16'h0000, 16'h0000, 0);
      fetch(16'd4, 16'hA882);                              // lw r2,r1,2 with 3 wait states
      mem_access(1'b0, 16'h0007, 16'h0000, 16'hBEEF, 3);
      fetch(16'd5, 16'h88FA);                              // sw r2,r1,-6 -> addr wraps
      mem_access(1'b1, 16'hFFFF, 16'hBEEF, 16'h0000, 0);
      fetch(16'd6, 16'h4D01);                              // nand r3,r2,r1 = FFFA
      exec_alu(16'd7);
      fetch(16'd7, 16'h73FF);                              // lui r4,0x3FF = FFC0
      exec_alu(16'd8);
      fetch(16'd8, 16'h1584);                              // add r5,r3,r4 = FFBA
      exec_alu(16'd9);
      fetch(16'd9, 16'h9400);                              // sw r5,r0,0
      mem_access(1'b1, 16'h0000, 16'hFFBA, 16'h0000, 0);
      fetch(16'd10, 16'hC505);                             // beq r1,r2,5 not taken
      exec_alu(16'd11);
      fetch(16'd11, 16'hC003);                             // beq r0,r0,3 taken
      exec_alu(16'd15);
      fetch(16'd15, 16'hF880);                             // jalr r6,r1
      exec_alu(16'd5);
      fetch(16'd5, 16'h9800);                              // sw r6,r0,0 -> 16
      mem_access(1'b1, 16'h0000, 16'h0010, 16'h0000, 0);
      fetch(16'd6, 16'hE480);                              // jalr r1,r1 uses old r1
      exec_alu(16'd5);
      fetch(16'd5, 16'h8400);                              // sw r1,r0,0 -> 7
      mem_access(1'b1, 16'h0000, 16'h0007, 16'h0000, 0);
      fetch(16'd6, 16'hC07F);                              // beq r0,r0,-1 spins
      exec_alu(16'd6);
      fetch(16'd6, 16'hC07F);
      exec_alu(16'd6);

      // Halt, with a stray ack that must be ignored
      fetch(16'd6, 16'hE001);
      chk("halt_exec_halted", 32'(o_halted), 32'd0);
      @(negedge i_clk);
      chk("halt_retire", 32'(o_retire), 32'd1);
      chk("halt_halted", 32'(o_halted), 32'd1);
      chk("halt_imem_req", 32'(o_imem_req), 32'd0);
      i_imem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge i_clk);
         chk("halt_retire_lo", 32'(o_retire), 32'd0);
         chk("halt_stays", 32'(o_halted), 32'd1);
         chk("halt_no_ireq", 32'(o_imem_req), 32'd0);
         chk("halt_no_dreq", 32'(o_dmem_req), 32'd0);
      end
      i_imem_ack = 1'b0;
      i_rst = 1'b1;
      #1;
      chk("halt_rst_clears", 32'(o_halted), 32'd0);
      @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);

      // Reset during a SW wait state
      fetch(16'd0, 16'h2409);                              // addi r1,r0,9
      exec_alu(16'd1);
      fetch(16'd1, 16'h8401);                              // sw r1,r0,1
      chk("abort_exec_dreq", 32'(o_dmem_req), 32'd0);
      @(negedge i_clk);
      chk("abort_mem_req", 32'(o_dmem_req), 32'd1);
      chk("abort_mem_addr", 32'(o_dmem_addr), 32'd1);
      chk("abort_mem_wdata", 32'(o_dmem_wdata), 32'd9);
      #2;
      i_rst = 1'b1;
      #1;
      chk("abort_dreq_drop", 32'(o_dmem_req), 32'd0);
      chk("abort_pc", 32'(o_imem_addr), 32'd0);
      @(negedge i_clk);
      i_rst = 1'b0;
      @(negedge i_clk);
      chk("abort_no_retire", 32'(o_retire), 32'd0);
      fetch(16'd0, 16'h8400);                              // sw r1,r0,0 -> r1 was cleared
      mem_access(1'b1, 16'h0000, 16'h0000, 16'h0000, 0);

      // PC wrap from 0xFFFF
      fetch(16'd1, 16'h247F);                              // addi r1,r0,-1
      exec_alu(16'd2);
      fetch(16'd2, 16'hE080);                              // jalr r0,r1
      exec_alu(16'hFFFF);
      fetch(16'hFFFF, 16'h0000);                           // add r0,r0,r0
      exec_alu(16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
